// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and address-map constants for the APB master arbiter.
package apb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_arb_state_e;

    localparam int unsigned DEFAULT_SLAVE_MEMORY_SIZE = 12;
    localparam int unsigned DEFAULT_SLAVE_MEMORY_GAP  = 2;

    function automatic int unsigned slave_stride(input int unsigned size_kb, input int unsigned gap_kb);
        return (size_kb + gap_kb) * 1024;
    endfunction

    function automatic int unsigned slave_window(input int unsigned size_kb);
        return size_kb * 1024;
    endfunction

    localparam int unsigned SLAVE_STRIDE = slave_stride(DEFAULT_SLAVE_MEMORY_SIZE, DEFAULT_SLAVE_MEMORY_GAP);
    localparam int unsigned SLAVE_WINDOW = slave_window(DEFAULT_SLAVE_MEMORY_SIZE);

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slave-window decoder: one constant-bound range check per slave,
// producing a one-hot select and a hit flag (no hit means the address falls in a gap).
module apb_addr_decoder
    import apb_master_arbiter_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          NO_OF_SLAVES  = 13,
    parameter int unsigned STRIDE_BYTES  = SLAVE_STRIDE,
    parameter int unsigned WINDOW_BYTES  = SLAVE_WINDOW
) (
    input  logic [ADDRESS_WIDTH-1:0] addr,
    output logic [NO_OF_SLAVES-1:0]  sel,
    output logic                     hit
);

    logic [63:0] addr_ext;

    assign addr_ext = 64'(addr);

    // Window 0 starts at address 0, so it only needs an upper bound.
    for (genvar i = 0; i < NO_OF_SLAVES; i++) begin : g_window
        localparam logic [63:0] BASE = 64'(i) * 64'(STRIDE_BYTES);
        localparam logic [63:0] LAST = BASE + 64'(WINDOW_BYTES) - 64'd1;
        if (i == 0) begin : g_first
            assign sel[i] = (addr_ext <= LAST);
        end else begin : g_rest
            assign sel[i] = (addr_ext >= BASE) && (addr_ext <= LAST);
        end
    end

    assign hit = |sel;

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among several requesters.
// Optional ACCESS wait-state timeout is built when APB_ARBITER_TIMEOUT_EN is defined.
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int NO_OF_REQUESTERS  = 4,
    parameter int NO_OF_SLAVES      = 13,
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int SLAVE_MEMORY_SIZE = 12,
    parameter int SLAVE_MEMORY_GAP  = 2,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic                                     pclk,
    input  logic                                     preset,
    input  logic [NO_OF_REQUESTERS-1:0]              req_valid,
    input  logic [NO_OF_REQUESTERS-1:0]              req_write,
    input  logic [NO_OF_REQUESTERS*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NO_OF_REQUESTERS*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NO_OF_REQUESTERS*(DATA_WIDTH/8)-1:0] req_strb,
    input  logic [NO_OF_REQUESTERS*3-1:0]            req_prot,
    output logic [NO_OF_REQUESTERS-1:0]              req_ack,
    output logic [NO_OF_REQUESTERS-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]                    rsp_rdata,
    output logic                                     rsp_slverr,
    output logic [ADDRESS_WIDTH-1:0]                 paddr,
    output logic [NO_OF_SLAVES-1:0]                  pselx,
    output logic                                     penable,
    output logic                                     pwrite,
    output logic [DATA_WIDTH-1:0]                    pwdata,
    output logic [DATA_WIDTH/8-1:0]                  pstrb,
    output logic [2:0]                               pprot,
    input  logic                                     pready,
    input  logic [DATA_WIDTH-1:0]                    prdata,
    input  logic                                     pslverr
);

    localparam int PTR_W  = (NO_OF_REQUESTERS > 1) ? $clog2(NO_OF_REQUESTERS) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    apb_arb_state_e state, next_state;

    logic [PTR_W-1:0]         rr_ptr, grant_idx, owner, pend_owner;
    logic                     grant_found, arb_en, grant_go, xfer_done, timeout_hit, err_pend;
    logic [ADDRESS_WIDTH-1:0] grant_addr;
    logic [NO_OF_SLAVES-1:0]  dec_sel;
    logic                     dec_hit;

    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] ptr, input int k);
        return PTR_W'((int'(ptr) + k) % NO_OF_REQUESTERS);
    endfunction

    function automatic logic [NO_OF_REQUESTERS-1:0] req_onehot(input logic [PTR_W-1:0] idx);
        return NO_OF_REQUESTERS'(1) << idx;
    endfunction

`ifdef APB_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts consecutive stalled ACCESS cycles; the last allowed stall aborts the transfer.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready && !timeout_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == ACCESS) && !pready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign xfer_done = (state == ACCESS) && (pready || timeout_hit);

    // An unmapped grant taken at a completing ACCESS leaves its error response pending;
    // arbitration pauses for that one cycle so two responses never collide.
    assign arb_en = !err_pend && ((state == IDLE) || xfer_done);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NO_OF_REQUESTERS; k++) begin
            if (!grant_found && req_valid[rr_index(rr_ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_index(rr_ptr, k);
            end
        end
    end

    assign grant_go   = arb_en && grant_found && !preset;
    assign req_ack    = grant_go ? req_onehot(grant_idx) : '0;
    assign grant_addr = req_addr[int'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    apb_addr_decoder #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NO_OF_SLAVES  (NO_OF_SLAVES),
        .STRIDE_BYTES  (slave_stride(SLAVE_MEMORY_SIZE, SLAVE_MEMORY_GAP)),
        .WINDOW_BYTES  (slave_window(SLAVE_MEMORY_SIZE))
    ) u_decoder (
        .addr (grant_addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_go && dec_hit) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (xfer_done) next_state = (grant_go && dec_hit) ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Later assignments win: a new mapped grant overrides the completion's pselx clear.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rr_ptr     <= '0;
            owner      <= '0;
            pend_owner <= '0;
            err_pend   <= 1'b0;
            paddr      <= '0;
            pselx      <= '0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            pstrb      <= '0;
            pprot      <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;

            if (state == SETUP) begin
                penable <= 1'b1;
            end

            if (xfer_done) begin
                pselx      <= '0;
                penable    <= 1'b0;
                rsp_valid  <= req_onehot(owner);
                rsp_slverr <= timeout_hit | pslverr;
                rsp_rdata  <= (timeout_hit || pwrite) ? '0 : prdata;
            end

            if (err_pend) begin
                err_pend   <= 1'b0;
                rsp_valid  <= req_onehot(pend_owner);
                rsp_slverr <= 1'b1;
            end

            if (grant_go) begin
                rr_ptr <= rr_index(grant_idx, 1);
                if (dec_hit) begin
                    owner   <= grant_idx;
                    paddr   <= grant_addr;
                    pwrite  <= req_write[grant_idx];
                    pwdata  <= req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    pstrb   <= req_strb[int'(grant_idx)*STRB_W +: STRB_W];
                    pprot   <= req_prot[int'(grant_idx)*3 +: 3];
                    pselx   <= dec_sel;
                    penable <= 1'b0;
                end else if (state == ACCESS) begin
                    err_pend   <= 1'b1;
                    pend_owner <= grant_idx;
                end else begin
                    rsp_valid  <= req_onehot(grant_idx);
                    rsp_slverr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter; the timeout case is
// exercised only when APB_ARBITER_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

    logic         pclk;
    logic         preset;
    logic [3:0]   req_valid;
    logic [3:0]   req_write;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_strb;
    logic [11:0]  req_prot;
    logic [3:0]   req_ack;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_slverr;
    logic [31:0]  paddr;
    logic [12:0]  pselx;
    logic         penable;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;
    logic         pready;
    logic [31:0]  prdata;
    logic         pslverr;

    int total = 0;
    int bad   = 0;

    logic [31:0] rr_addr [4];
    logic [12:0] rr_sel  [4];

    apb_master_arbiter dut (
        .pclk       (pclk),
        .preset     (preset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strb   (req_strb),
        .req_prot   (req_prot),
        .req_ack    (req_ack),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .paddr      (paddr),
        .pselx      (pselx),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pprot      (pprot),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        req_write[idx]          = wr;
        req_addr[idx*32 +: 32]  = addr;
        req_wdata[idx*32 +: 32] = wdata;
        req_strb[idx*4 +: 4]    = 4'hF;
        req_prot[idx*3 +: 3]    = 3'(idx);
        req_valid[idx]          = 1'b1;
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        rr_addr = '{32'h0000_0010, 32'h0000_3900, 32'h0000_7004, 32'h0000_A800};
        rr_sel  = '{13'h0001, 13'h0002, 13'h0004, 13'h0008};

        preset    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;

        #2;
        checkOutput("rst_pselx", pselx, 0);
        checkOutput("rst_penable", penable, 0);
        checkOutput("rst_paddr", paddr, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_req_ack", req_ack, 0);
        tick();
        preset = 1'b0;
        tick();

        // single read to slave 1
        applyStimulus(0, 1'b0, 32'h0000_3804, 32'h0);
        #1 checkOutput("rd_ack", req_ack, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        #1;
        checkOutput("rd_setup_pselx", pselx, 13'h0002);
        checkOutput("rd_setup_penable", penable, 0);
        checkOutput("rd_setup_paddr", paddr, 32'h0000_3804);
        checkOutput("rd_setup_pwrite", pwrite, 0);
        tick();
        pready = 1'b1;
        prdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("rd_access_penable", penable, 1);
        checkOutput("rd_access_pselx", pselx, 13'h0002);
        tick();
        pready = 1'b0;
        #1;
        checkOutput("rd_rsp_valid", rsp_valid, 4'b0001);
        checkOutput("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        checkOutput("rd_rsp_slverr", rsp_slverr, 0);
        checkOutput("rd_idle_pselx", pselx, 0);
        checkOutput("rd_idle_penable", penable, 0);
        checkOutput("rd_idle_paddr", paddr, 32'h0000_3804);

        // gap address inside slave-0 gap, then address past slave 12
        applyStimulus(1, 1'b0, 32'h0000_3000, 32'h0);
        #1 checkOutput("gap_ack", req_ack, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        #1;
        checkOutput("gap_rsp_valid", rsp_valid, 4'b0010);
        checkOutput("gap_rsp_slverr", rsp_slverr, 1);
        checkOutput("gap_rsp_rdata", rsp_rdata, 0);
        checkOutput("gap_pselx", pselx, 0);
        applyStimulus(2, 1'b0, 32'h0002_D800, 32'h0);
        #1 checkOutput("top_ack", req_ack, 4'b0100);
        tick();
        req_valid[2] = 1'b0;
        #1;
        checkOutput("top_rsp_valid", rsp_valid, 4'b0100);
        checkOutput("top_rsp_slverr", rsp_slverr, 1);
        checkOutput("top_pselx", pselx, 0);
        checkOutput("top_penable", penable, 0);

        // write to last byte of slave 12 with three wait states and an error
        applyStimulus(3, 1'b1, 32'h0002_CFFF, 32'h1234_5678);
        #1 checkOutput("ws_ack", req_ack, 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        #1;
        checkOutput("ws_setup_pselx", pselx, 13'h1000);
        checkOutput("ws_setup_pwrite", pwrite, 1);
        checkOutput("ws_setup_pprot", pprot, 3'd3);
        checkOutput("ws_setup_pstrb", pstrb, 4'hF);
        for (int w = 0; w < 3; w++) begin
            tick();
            #1;
            checkOutput("ws_wait_penable", penable, 1);
            checkOutput("ws_wait_pselx", pselx, 13'h1000);
            checkOutput("ws_wait_paddr", paddr, 32'h0002_CFFF);
            checkOutput("ws_wait_pwdata", pwdata, 32'h1234_5678);
            checkOutput("ws_wait_rsp_valid", rsp_valid, 0);
        end
        tick();
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hFFFF_FFFF;
        #1 checkOutput("ws_done_penable", penable, 1);
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        #1;
        checkOutput("ws_rsp_valid", rsp_valid, 4'b1000);
        checkOutput("ws_rsp_slverr", rsp_slverr, 1);
        checkOutput("ws_rsp_rdata", rsp_rdata, 0);
        checkOutput("ws_idle_pselx", pselx, 0);

        // reset while in ACCESS
        applyStimulus(1, 1'b0, 32'h0000_0000, 32'h0);
        #1 checkOutput("mr_ack", req_ack, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        #1 checkOutput("mr_setup_pselx", pselx, 13'h0001);
        tick();
        #1 checkOutput("mr_access_penable", penable, 1);
        preset = 1'b1;
        #1;
        checkOutput("mr_pselx", pselx, 0);
        checkOutput("mr_penable", penable, 0);
        checkOutput("mr_paddr", paddr, 0);
        checkOutput("mr_rsp_valid", rsp_valid, 0);
        tick();
        tick();
        preset = 1'b0;
        tick();
        #1;
        checkOutput("mr_after_rsp_valid", rsp_valid, 0);
        checkOutput("mr_after_pselx", pselx, 0);

        // round-robin from reset: all four valid, back-to-back transfers
        pready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, 1'b0, rr_addr[i], 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            #1 checkOutput("rr_ack", req_ack, 64'(4'b0001 << i));
            tick();
            req_valid[i] = 1'b0;
            #1;
            checkOutput("rr_setup_pselx", pselx, rr_sel[i]);
            checkOutput("rr_setup_penable", penable, 0);
            checkOutput("rr_setup_paddr", paddr, rr_addr[i]);
            if (i > 0) begin
                checkOutput("rr_rsp_valid", rsp_valid, 64'(4'b0001 << (i - 1)));
                checkOutput("rr_rsp_rdata", rsp_rdata, 64'(32'hA0 + i - 1));
            end
            tick();
            prdata = 32'hA0 + 32'(i);
        end
        #1;
        checkOutput("rr_last_ack", req_ack, 0);
        checkOutput("rr_last_penable", penable, 1);
        tick();
        #1;
        checkOutput("rr_last_rsp_valid", rsp_valid, 4'b1000);
        checkOutput("rr_last_rsp_rdata", rsp_rdata, 32'hA3);
        checkOutput("rr_last_pselx", pselx, 0);
        pready = 1'b0;

`ifdef APB_ARBITER_TIMEOUT_EN
        // slave never ready: abort after sixteen stalled ACCESS cycles
        prdata = 32'h5555_5555;
        applyStimulus(0, 1'b0, 32'h0000_3804, 32'h0);
        #1 checkOutput("to_ack", req_ack, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            #1;
            checkOutput("to_wait_penable", penable, 1);
            checkOutput("to_wait_rsp_valid", rsp_valid, 0);
        end
        tick();
        #1;
        checkOutput("to_pselx", pselx, 0);
        checkOutput("to_penable", penable, 0);
        checkOutput("to_rsp_valid", rsp_valid, 4'b0001);
        checkOutput("to_rsp_slverr", rsp_slverr, 1);
        checkOutput("to_rsp_rdata", rsp_rdata, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
